// File: rtl/exa_crosb_vc_credit_tracker.sv
// -----------------------------------------------------------------------------
// exa_crosb_vc_credit_tracker
//
// Per-output, per-VC credit counter bank for the crossbar. Every counter tracks
// the free packet slots of one output FIFO virtual channel:
//   - crossbar grants (packet starts) consume one credit each,
//   - output FIFO credit returns give one credit back.
// Counters saturate at 0 and max_credits. Saturation and malformed pulses raise
// sticky error flags that only reset clears.
//
// After reset the block walks an INIT phase that loads every counter, one per
// cycle (output-major, then VC), with min(i_init_credits, max_credits). It then
// stays in RUN until the next reset.
//
// Optional feature macro: EXA_CREDIT_THRESHOLD_EN
//   defined   : credit flag = o_ready && count >= credit_threshold
//               (elaboration error if credit_threshold is 0 or > max_credits)
//   undefined : credit flag = o_ready && count != 0
//
// Ports:
//   clk                    clock, all state on posedge
//   reset                  asynchronous active-high reset
//   i_init_credits         value loaded into every counter during INIT
//   i_consume_valid[k]     grant pulse from crossbar input k
//   i_consume_output[k]    destination output of that grant
//   i_consume_vc[k]        destination VC of that grant
//   i_return_valid[o]      output FIFO o freed one packet slot
//   i_return_vc[o]         VC of that returned credit
//   o_output_fifo_credits  credit-available flag per output/VC
//   o_credit_count         live counter values per output/VC
//   o_ready                high in RUN
//   o_underflow_err        sticky: counter went below 0, or pulse during INIT
//   o_overflow_err         sticky: counter exceeded max_credits, or bad index
// -----------------------------------------------------------------------------
module exa_crosb_vc_credit_tracker #(
  parameter int prio_num         = 2,
  parameter int vc_num           = 3,
  parameter int input_num        = 2,
  parameter int output_num       = 2,
  parameter int max_credits      = 8,
  parameter int credit_threshold = 2,
  localparam int NVC             = prio_num * vc_num,
  localparam int credit_width    = $clog2(max_credits + 1),
  localparam int OW              = (output_num > 1) ? $clog2(output_num) : 1,
  localparam int VW              = (NVC > 1) ? $clog2(NVC) : 1
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [credit_width-1:0]                         i_init_credits,
  input  logic [input_num-1:0]                            i_consume_valid,
  input  logic [input_num-1:0][OW-1:0]                    i_consume_output,
  input  logic [input_num-1:0][VW-1:0]                    i_consume_vc,
  input  logic [output_num-1:0]                           i_return_valid,
  input  logic [output_num-1:0][VW-1:0]                   i_return_vc,
  output logic [output_num-1:0][NVC-1:0]                  o_output_fifo_credits,
  output logic [output_num-1:0][NVC-1:0][credit_width-1:0] o_credit_count,
  output logic                                            o_ready,
  output logic                                            o_underflow_err,
  output logic                                            o_overflow_err
);

  localparam int TOTAL = output_num * NVC;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  // Two extra bits: one for the sign, one for headroom above max_credits.
  localparam int SW    = credit_width + 2;

  localparam logic [credit_width-1:0] MAX_C = credit_width'(max_credits);
  localparam logic signed [SW-1:0]    MAX_S = SW'(max_credits);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_reg;
  logic [IW-1:0]           index_reg;
  logic                    ready_reg;
  logic                    underflow_reg;
  logic                    overflow_reg;
  logic [credit_width-1:0] init_value;
  logic [TOTAL-1:0]        under_vec;
  logic [TOTAL-1:0]        over_vec;
  logic                    any_pulse;
  logic                    range_err;

`ifdef EXA_CREDIT_THRESHOLD_EN
  if (credit_threshold > max_credits || credit_threshold == 0) begin : g_bad_threshold
    $error("credit_threshold must lie in 1..max_credits");
  end
`endif

  assign init_value = (i_init_credits > MAX_C) ? MAX_C : i_init_credits;
  assign any_pulse  = (|i_consume_valid) || (|i_return_valid);

  // Pulses that address a nonexistent output or VC match no counter, so they
  // are dropped naturally; they only need to be flagged here.
  always_comb begin
    range_err = 1'b0;
    for (int k = 0; k < input_num; k++) begin
      if (i_consume_valid[k] &&
          ((int'(i_consume_output[k]) >= output_num) || (int'(i_consume_vc[k]) >= NVC)))
        range_err = 1'b1;
    end
    for (int o = 0; o < output_num; o++) begin
      if (i_return_valid[o] && (int'(i_return_vc[o]) >= NVC))
        range_err = 1'b1;
    end
  end

  for (genvar gi = 0; gi < output_num; gi++) begin : g_out
    for (genvar gj = 0; gj < NVC; gj++) begin : g_vc
      localparam int CI = gi * NVC + gj;

      logic [credit_width-1:0] count_reg;
      logic [credit_width-1:0] count_next;
      logic signed [SW-1:0]    sum;
      logic [SW-1:0]           dec;
      logic                    inc;
      logic                    under_c;
      logic                    over_c;

      // Several inputs granted onto the same counter in one cycle are summed.
      always_comb begin
        dec = '0;
        for (int k = 0; k < input_num; k++) begin
          if (i_consume_valid[k] && (int'(i_consume_output[k]) == gi) &&
              (int'(i_consume_vc[k]) == gj))
            dec = dec + SW'(1);
        end
        inc        = i_return_valid[gi] && (int'(i_return_vc[gi]) == gj);
        sum        = signed'(SW'(count_reg)) + signed'(SW'(inc)) - signed'(dec);
        under_c    = 1'b0;
        over_c     = 1'b0;
        count_next = sum[credit_width-1:0];
        if (sum < 0) begin
          count_next = '0;
          under_c    = 1'b1;
        end else if (sum > MAX_S) begin
          count_next = MAX_C;
          over_c     = 1'b1;
        end
      end

      assign under_vec[CI] = under_c;
      assign over_vec[CI]  = over_c;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_reg <= '0;
        end else if (state_reg == ST_INIT) begin
          if (index_reg == IW'(CI))
            count_reg <= init_value;
        end else begin
          count_reg <= count_next;
        end
      end

      assign o_credit_count[gi][gj] = count_reg;
`ifdef EXA_CREDIT_THRESHOLD_EN
      assign o_output_fifo_credits[gi][gj] =
        ready_reg && (count_reg >= credit_width'(credit_threshold));
`else
      assign o_output_fifo_credits[gi][gj] = ready_reg && (count_reg != '0);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      index_reg     <= '0;
      ready_reg     <= 1'b0;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          // Counters are not yet valid: any traffic is a protocol violation.
          if (any_pulse)
            underflow_reg <= 1'b1;
          if (index_reg == IW'(TOTAL - 1)) begin
            state_reg <= ST_RUN;
            ready_reg <= 1'b1;
          end else begin
            index_reg <= index_reg + IW'(1);
          end
        end
        ST_RUN: begin
          if (|under_vec)
            underflow_reg <= 1'b1;
          if ((|over_vec) || range_err)
            overflow_reg <= 1'b1;
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign o_ready         = ready_reg;
  assign o_underflow_err = underflow_reg;
  assign o_overflow_err  = overflow_reg;

endmodule

// File: tb/tb_exa_crosb_vc_credit_tracker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for exa_crosb_vc_credit_tracker (default parameters).
// A behavioural model predicts the post-edge state for every driven cycle;
// predictions are queued when stimulus is applied and compared after the edge.
// -----------------------------------------------------------------------------
module tb_exa_crosb_vc_credit_tracker;

  localparam int NO   = 2;
  localparam int NV   = 6;
  localparam int NI   = 2;
  localparam int MAXC = 8;
  localparam int THR  = 2;
`ifdef EXA_CREDIT_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [3:0]           init_credits;
  logic [1:0]           consume_valid;
  logic [1:0][0:0]      consume_output;
  logic [1:0][2:0]      consume_vc;
  logic [1:0]           return_valid;
  logic [1:0][2:0]      return_vc;
  logic [1:0][5:0]      fifo_credits;
  logic [1:0][5:0][3:0] credit_count;
  logic                 ready;
  logic                 underflow_err;
  logic                 overflow_err;

  exa_crosb_vc_credit_tracker dut (
    .clk                   (clk),
    .reset                 (reset),
    .i_init_credits        (init_credits),
    .i_consume_valid       (consume_valid),
    .i_consume_output      (consume_output),
    .i_consume_vc          (consume_vc),
    .i_return_valid        (return_valid),
    .i_return_vc           (return_vc),
    .o_output_fifo_credits (fifo_credits),
    .o_credit_count        (credit_count),
    .o_ready               (ready),
    .o_underflow_err       (underflow_err),
    .o_overflow_err        (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int o;      // -1 marks the per-cycle status entry
    int v;
    int cnt;
    bit flag;
    bit rdy;
    bit under;
    bit over;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  int m_cnt[NO][NV];
  int m_idx;
  bit m_ready, m_under, m_over;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_flag(input int c);
    return m_ready && (THR_EN ? (c >= THR) : (c != 0));
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++) m_cnt[o][v] = 0;
    m_idx = 0; m_ready = 0; m_under = 0; m_over = 0;
  endtask

  // Predict the state after the next rising edge from the inputs now driven.
  task automatic model_step();
    int nc[NO][NV];
    int dec, n;
    bit inc;
    if (!m_ready) begin
      if ((consume_valid != 0) || (return_valid != 0)) m_under = 1;
      m_cnt[m_idx / NV][m_idx % NV] = (int'(init_credits) > MAXC) ? MAXC : int'(init_credits);
      m_idx++;
      if (m_idx == NO * NV) m_ready = 1;
    end else begin
      for (int o = 0; o < NO; o++) begin
        for (int v = 0; v < NV; v++) begin
          dec = 0;
          for (int k = 0; k < NI; k++)
            if (consume_valid[k] && int'(consume_output[k]) == o && int'(consume_vc[k]) == v)
              dec++;
          inc = return_valid[o] && (int'(return_vc[o]) == v);
          n = m_cnt[o][v] + int'(inc) - dec;
          if (n < 0) begin n = 0; m_under = 1; end
          else if (n > MAXC) begin n = MAXC; m_over = 1; end
          nc[o][v] = n;
        end
      end
      for (int k = 0; k < NI; k++)
        if (consume_valid[k] && int'(consume_vc[k]) >= NV) m_over = 1;
      for (int o = 0; o < NO; o++)
        if (return_valid[o] && int'(return_vc[o]) >= NV) m_over = 1;
      m_cnt = nc;
    end
  endtask

  task automatic run_cycle(input int ob, input int vb, input bit all);
    exp_t e;
    $display("cyc %0d: cv=%b co=%h cvc=%h rv=%b rvc=%h", cyc, consume_valid,
             consume_output, consume_vc, return_valid, return_vc);
    model_step();
    e = '{o: -1, v: 0, cnt: 0, flag: 0, rdy: m_ready, under: m_under, over: m_over};
    sb_q.push_back(e);
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++)
        if (all || (o == ob && v == vb)) begin
          e = '{o: o, v: v, cnt: m_cnt[o][v], flag: exp_flag(m_cnt[o][v]),
                rdy: 0, under: 0, over: 0};
          sb_q.push_back(e);
        end
    @(posedge clk); #1;
    consume_valid = '0;
    return_valid  = '0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.o < 0) begin
        check($sformatf("ready@%0d", cyc), 64'(ready), 64'(e.rdy));
        check($sformatf("underflow@%0d", cyc), 64'(underflow_err), 64'(e.under));
        check($sformatf("overflow@%0d", cyc), 64'(overflow_err), 64'(e.over));
      end else begin
        check($sformatf("cnt[%0d][%0d]@%0d", e.o, e.v, cyc),
              64'(credit_count[e.o][e.v]), 64'(e.cnt));
        check($sformatf("flag[%0d][%0d]@%0d", e.o, e.v, cyc),
              64'(fifo_credits[e.o][e.v]), 64'(e.flag));
      end
    end
    cyc++;
  endtask

  task automatic set_consume(input int k, input int o, input int v);
    consume_valid[k]  = 1'b1;
    consume_output[k] = 1'(o);
    consume_vc[k]     = 3'(v);
  endtask

  task automatic set_return(input int o, input int v);
    return_valid[o] = 1'b1;
    return_vc[o]    = 3'(v);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 64'(ready), 64'd0);
    check({tag, "_under"}, 64'(underflow_err), 64'd0);
    check({tag, "_over"}, 64'(overflow_err), 64'd0);
    check({tag, "_flags"}, 64'(fifo_credits), 64'd0);
    check({tag, "_counts"}, 64'(credit_count), 64'd0);
  endtask

  initial begin
    init_credits   = 4'd8;
    consume_valid  = '0;
    consume_output = '0;
    consume_vc     = '0;
    return_valid   = '0;
    return_vc      = '0;
    model_reset();

    // Reset and first INIT: o_ready must rise on exactly the 12th edge.
    #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_reset_state("rst");
    reset = 1'b0;
    for (int i = 0; i < NO * NV; i++) run_cycle(0, 0, i == NO * NV - 1);

    // out0/VC0 drained by double grants, then consume+return at 0, then return.
    for (int i = 0; i < 4; i++) begin
      set_consume(0, 0, 0); set_consume(1, 0, 0);
      run_cycle(0, 0, 0);
    end
    set_consume(0, 0, 0); set_return(0, 0);
    run_cycle(0, 0, 0);
    set_return(0, 0);
    run_cycle(0, 0, 0);

    // out0/VC3 from 8 to 1 (flag behaviour near the threshold), then back to 2.
    for (int i = 0; i < 7; i++) begin
      set_consume(i % 2, 0, 3);
      run_cycle(0, 3, 0);
    end
    set_return(0, 3);
    run_cycle(0, 3, 0);

    // out1/VC5 to 1, then two inputs in one cycle: saturates at 0, underflow.
    for (int i = 0; i < 7; i++) begin
      set_consume(i % 2, 1, 5);
      run_cycle(1, 5, 0);
    end
    set_consume(0, 1, 5); set_consume(1, 1, 5);
    run_cycle(1, 5, 1);

    // Out-of-range VC on a consume and a return: dropped, overflow flagged.
    set_consume(0, 0, 7); set_return(1, 6);
    run_cycle(0, 0, 1);

    // Reset with an oversized init value, interrupted mid-INIT at index 5.
    reset = 1'b1; #1;
    model_reset();
    check_reset_state("rst2");
    @(posedge clk); #1;
    reset = 1'b0;
    init_credits = 4'd15;
    for (int i = 0; i < 5; i++) run_cycle(0, 0, 0);
    reset = 1'b1; #1;
    model_reset();
    check_reset_state("rst_midinit");
    @(posedge clk); #1;
    reset = 1'b0;
    // Consume during INIT: protocol violation, no counter change.
    set_consume(0, 1, 2);
    run_cycle(1, 2, 0);
    for (int i = 1; i < NO * NV; i++) run_cycle(0, 0, i == NO * NV - 1);

    // Return on a full counter: stays at max, overflow flagged.
    set_return(0, 2);
    run_cycle(0, 2, 1);

    // Random traffic, including occasional out-of-range VCs.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < NI; k++)
        if ($urandom_range(0, 1) == 1)
          set_consume(k, int'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
      for (int o = 0; o < NO; o++)
        if ($urandom_range(0, 2) != 0)
          set_return(o, int'($urandom_range(0, 6)));
      run_cycle(0, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
